// File: rtl/fpu_div_seq.sv
// fpu_div_seq: multi-cycle IEEE-754 divider with radix-2 restoring iteration.
// The format is set by EXP_W/FRAC_W; the defaults give binary64.
// Rounding is round-to-nearest-even. Subnormal operands and results are
// flushed to signed zero.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. in_ready is 1 only in IDLE. Once
// out_valid rises, result and flags hold until out_ready is seen, and the
// unit then returns to IDLE. It never accepts new operands in the same cycle
// it hands off a result.
//
// Timeline after the accept edge:
//   edge 1          : the first DIVIDE cycle unpacks and classifies the
//                     operands. A special case goes straight to DONE.
//   edges 2..Q+1    : Q quotient iterations.
//   edge Q+2        : ROUND produces the result and enters DONE.
module fpu_div_seq #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXP_W+FRAC_W:0]     a,
   input  logic [EXP_W+FRAC_W:0]     b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+FRAC_W:0]     result,
   output logic [4:0]                flags,
   output logic [1:0]                dbg_state
);

   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int M     = FRAC_W + 1;          // mantissa width including the hidden bit
   localparam int Q     = FRAC_W + 2;          // quotient bits: integer, fraction, guard
   localparam int EW2   = EXP_W + 2;           // signed working exponent width
   localparam int CNT_W = $clog2(Q + 1);

   localparam logic [EW2-1:0]   BIAS_X = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW2-1:0]   EMAX   = EW2'((1 << EXP_W) - 1);
   localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(Q);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state_q;
   logic [W-1:0]        a_q, b_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [M:0]          rem_q;
   // Only the fraction and guard bits are kept. The integer quotient bit is
   // always 1 and is shifted out of the top.
   logic [FRAC_W:0]     quo_q;
   logic [EW2-1:0]      exp_q;
   logic [W-1:0]        result_q;
   logic [4:0]          flags_q;
   logic                out_valid_q;

   // Operand fields; subnormals count as zero because only exp == 0 is tested
   logic                sign_a, sign_b, res_sign;
   logic [EXP_W-1:0]    ea, eb;
   logic [FRAC_W-1:0]   fa, fb;
   logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [W-1:0]        qnan_val, inf_val, zero_val;

   assign sign_a   = a_q[W-1];
   assign sign_b   = b_q[W-1];
   assign ea       = a_q[W-2:FRAC_W];
   assign eb       = b_q[W-2:FRAC_W];
   assign fa       = a_q[FRAC_W-1:0];
   assign fb       = b_q[FRAC_W-1:0];
   assign res_sign = sign_a ^ sign_b;

   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);

   assign qnan_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
   assign inf_val  = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   assign zero_val = {res_sign, {(W-1){1'b0}}};

   // Special-case classification: NaN, infinity and zero operands bypass the iteration
   logic          spec_hit_d;
   logic [W-1:0]  spec_res_d;
   logic [4:0]    spec_flags_d;

   always_comb begin
      spec_hit_d   = 1'b1;
      spec_res_d   = zero_val;
      spec_flags_d = 5'b00000;
      if (a_nan || b_nan) begin
         spec_res_d   = qnan_val;
         spec_flags_d = {(a_nan && !fa[FRAC_W-1]) || (b_nan && !fb[FRAC_W-1]), 4'b0000};
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res_d   = qnan_val;
         spec_flags_d = 5'b10000;
      end else if (a_inf) begin
         spec_res_d   = inf_val;
      end else if (b_inf) begin
         spec_res_d   = zero_val;
      end else if (b_zero) begin
         spec_res_d   = inf_val;
         spec_flags_d = 5'b01000;
      end else if (a_zero) begin
         spec_res_d   = zero_val;
      end else begin
         spec_hit_d   = 1'b0;
      end
   end

   // Normal-path setup: pre-shift the dividend so the first quotient bit is always 1
   logic [M-1:0]   ma, mb;
   logic           ma_lt_mb;
   logic [M:0]     rem_init_d;
   logic [EW2-1:0] exp_init_d;

   assign ma         = {1'b1, fa};
   assign mb         = {1'b1, fb};
   assign ma_lt_mb   = (ma < mb);
   assign rem_init_d = ma_lt_mb ? {ma, 1'b0} : {1'b0, ma};
   assign exp_init_d = {2'b00, ea} - {2'b00, eb} + BIAS_X - {{(EW2-1){1'b0}}, ma_lt_mb};

   // One restoring step: subtract the divisor when it fits, then shift the remainder left
   logic           quo_bit;
   logic [M:0]     rem_sub_d, rem_next_d;
   logic [FRAC_W:0] quo_next_d;

   assign quo_bit    = (rem_q >= {1'b0, mb});
   assign rem_sub_d  = quo_bit ? (rem_q - {1'b0, mb}) : rem_q;
   assign rem_next_d = rem_sub_d << 1;
   assign quo_next_d = {quo_q[FRAC_W-1:0], quo_bit};

   // Rounding, exponent adjustment on carry-out, and range checks
   logic            g_bit, s_bit, lsb_bit, round_up;
   logic [FRAC_W:0] frac_sum_d;
   logic            carry;
   logic [EW2-1:0]  exp_rnd_d;
   logic            ovf, unf;
   logic [W-1:0]    round_res_d;
   logic [4:0]      round_flags_d;

   assign g_bit      = quo_q[0];
   assign lsb_bit    = quo_q[1];
   assign s_bit      = (rem_q != '0);
   assign round_up   = g_bit & (s_bit | lsb_bit);
   assign frac_sum_d = {1'b0, quo_q[FRAC_W:1]} + {{FRAC_W{1'b0}}, round_up};
   // A fraction carry means the mantissa went from 1.11..1 to 10.00..0
   assign carry      = frac_sum_d[FRAC_W];
   assign exp_rnd_d  = exp_q + {{(EW2-1){1'b0}}, carry};
   assign ovf        = !exp_rnd_d[EW2-1] && (exp_rnd_d >= EMAX);
   assign unf        = exp_rnd_d[EW2-1] || (exp_rnd_d == '0);

   // Final result selection after rounding
   always_comb begin
      round_res_d   = {res_sign, exp_rnd_d[EXP_W-1:0], frac_sum_d[FRAC_W-1:0]};
      round_flags_d = {4'b0000, g_bit | s_bit};
      if (ovf) begin
         round_res_d   = inf_val;
         round_flags_d = 5'b00101;
      end else if (unf) begin
         round_res_d   = zero_val;
         round_flags_d = 5'b00011;
      end
   end

   // Control FSM with registered outputs; reset aborts any division in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         exp_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  cnt_q   <= '0;
                  state_q <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (cnt_q == '0) begin
                  if (spec_hit_d) begin
                     result_q    <= spec_res_d;
                     flags_q     <= spec_flags_d;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     rem_q <= rem_init_d;
                     exp_q <= exp_init_d;
                     cnt_q <= CNT_W'(1);
                  end
               end else begin
                  rem_q <= rem_next_d;
                  quo_q <= quo_next_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == Q_LAST) begin
                     state_q <= ROUND;
                  end
               end
            end
            ROUND: begin
               result_q    <= round_res_d;
               flags_q     <= round_flags_d;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: binary64 instance plus a binary32 instance.
module tb_fpu_div_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // binary64 instance
  logic        v64 = 1'b0, r64, ov64, ordy64 = 1'b1;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic [4:0]  fl64;
  logic [1:0]  st64;

  // binary32 instance
  logic        v32 = 1'b0, r32, ov32, ordy32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [4:0]  fl32;
  logic [1:0]  st32;

  fpu_div_seq u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(ordy64), .result(res64), .flags(fl64), .dbg_state(st64)
  );

  fpu_div_seq #(.EXP_W(8), .FRAC_W(23)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(ordy32), .result(res32), .flags(fl32), .dbg_state(st32)
  );

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_ov(input bit sp);
    return sp ? ov32 : ov64;
  endfunction

  function automatic logic get_rdy(input bit sp);
    return sp ? r32 : r64;
  endfunction

  function automatic logic [63:0] get_res(input bit sp);
    return sp ? {32'h0, res32} : res64;
  endfunction

  function automatic logic [4:0] get_fl(input bit sp);
    return sp ? fl32 : fl64;
  endfunction

  // ---------------- driver ----------------
  // Waits for in_ready, presents one operand pair, measures latency and checks
  // the result; out_ready is held high so the result is taken at once.
  task automatic run_op(input bit sp, input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_r, input logic [4:0] exp_f,
                        input int exp_lat, input string tag);
    int n;
    int lat;
    int busy_bad;
    n = 0;
    while (!get_rdy(sp) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sp) begin a32 = av[31:0]; b32 = bv[31:0]; v32 = 1'b1; end
    else begin a64 = av; b64 = bv; v64 = 1'b1; end
    @(posedge clk);             // accept edge
    #1;
    v32 = 1'b0; v64 = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!get_ov(sp) && lat < 200) begin
      if (get_rdy(sp)) busy_bad++;
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("%s/latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s/result", tag), get_res(sp), exp_r);
    chk($sformatf("%s/flags", tag), 64'(get_fl(sp)), 64'(exp_f));
    chk($sformatf("%s/in_ready_busy", tag), 64'(busy_bad), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("%s/out_valid_drop", tag), 64'(get_ov(sp)), 64'd0);
    chk($sformatf("%s/in_ready_back", tag), 64'(get_rdy(sp)), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int bp_bad;
    int stale;

    // reset state
    #12;
    chk("rst/out_valid", 64'(ov64), 64'd0);
    chk("rst/result", res64, 64'd0);
    chk("rst/flags", 64'(fl64), 64'd0);
    chk("rst/in_ready", 64'(r64), 64'd1);
    chk("rst/state", 64'(st64), 64'd0);
    chk("rst/in_ready32", 64'(r32), 64'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // exact quotient and sign
    run_op(0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'h00, 56, "six_div_two");
    run_op(0, 64'h4018000000000000, 64'hC000000000000000, 64'hC008000000000000, 5'h00, 56, "six_div_neg_two");

    // rounding
    run_op(0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'h01, 56, "one_third_d");
    run_op(1, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 5'h01, 27, "one_third_s");

    // specials
    run_op(0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'h08, 1, "one_div_zero");
    run_op(0, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'h10, 1, "zero_div_zero");
    run_op(0, 64'hC000000000000000, 64'h7FF0000000000000, 64'h8000000000000000, 5'h00, 1, "neg_two_div_inf");
    run_op(0, 64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 5'h00, 1, "subnormal_flush");
    run_op(0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'h10, 1, "snan_in");
    run_op(0, 64'hFFF8000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'h00, 1, "qnan_in");
    run_op(0, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'h10, 1, "inf_div_inf");
    run_op(0, 64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 5'h00, 1, "neg_inf_div_two");

    // range limits
    run_op(0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'h05, 56, "overflow");
    run_op(0, 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'h03, 56, "underflow");

    // backpressure
    ordy64 = 1'b0;
    n = 0;
    while (!r64 && n < 100) begin @(posedge clk); #1; n++; end
    a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    n = 0;
    while (!ov64 && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp/latency", 64'(n), 64'd56);
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      v64 = (i % 2 == 0);
      a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000;
      @(posedge clk); #1;
      if (ov64 !== 1'b1) bp_bad++;
      if (res64 !== 64'h4008000000000000) bp_bad++;
      if (fl64 !== 5'h00) bp_bad++;
      if (r64 !== 1'b0) bp_bad++;
    end
    v64 = 1'b0;
    chk("bp/hold_stable", 64'(bp_bad), 64'd0);
    chk("bp/result_held", res64, 64'h4008000000000000);
    ordy64 = 1'b1;
    @(posedge clk); #1;
    chk("bp/out_valid_drop", 64'(ov64), 64'd0);
    chk("bp/in_ready_back", 64'(r64), 64'd1);
    run_op(0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'h01, 56, "bp_next");

    // reset mid-divide
    n = 0;
    while (!r64 && n < 100) begin @(posedge clk); #1; n++; end
    a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/out_valid", 64'(ov64), 64'd0);
    chk("midrst/result", res64, 64'd0);
    chk("midrst/flags", 64'(fl64), 64'd0);
    chk("midrst/in_ready", 64'(r64), 64'd1);
    chk("midrst/state", 64'(st64), 64'd0);
    #4 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ov64 !== 1'b0) stale++;
    end
    chk("midrst/no_stale", 64'(stale), 64'd0);
    run_op(0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'h00, 56, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_div_seq.md
Name: fpu_div_seq

Overview:
- Parametrised, multi-cycle IEEE-754 divider that succeeds the combinational double-precision divide path.
- Generic in format through EXP_W and FRAC_W; defaults give binary64.
- Uses a radix-2 restoring iteration, round-to-nearest-even, exception flags and valid/ready handshakes on both sides.
- Sits beside the FPU datapath as the long-latency divide unit.

Parameters:
EXP_W, 11, exponent field width; BIAS = 2^(EXP_W-1)-1 is derived.
FRAC_W, 52, stored fraction width; word width W = 1+EXP_W+FRAC_W.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  unit can accept operands.
a  input  W  dividend.
b  input  W  divisor.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  W  quotient, a/b.
flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}; invalid is bit 4.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE, out_valid=0, result=0, flags=0.
  - in_ready=1 in IDLE, including directly after reset.
- Reset mid-operation aborts the division; no result is emitted.
- FSM states are IDLE, DIVIDE, ROUND and DONE.
  - in_ready = (state==IDLE).
  - An input handshake (in_valid & in_ready) registers the operands.
- Subnormal inputs (exp=0) are flushed to signed zero before classification. Flushing does not raise a flag.
- Special cases go IDLE->DONE, so out_valid rises on the 1st edge after the accept edge:
  - Any NaN input gives qNaN {0, all-ones exp, 1, zeros}. invalid is set if either NaN is signalling (frac MSB=0).
  - 0/0 and inf/inf give qNaN with invalid.
  - inf/finite gives signed inf, flags=0.
  - finite/inf gives signed zero, flags=0.
  - nonzero finite/0 gives signed inf with div_by_zero.
  - 0/nonzero finite gives signed zero, flags=0.
- Sign is a[W-1]^b[W-1] for every non-NaN result.
- Normal path:
  - ma={1,fa}, mb={1,fb}.
  - If ma<mb: dividend = ma<<1 and e = ea-eb+BIAS-1. Otherwise e = ea-eb+BIAS.
  - e is held signed, EXP_W+2 bits wide.
- DIVIDE:
  - Runs Q = FRAC_W+2 cycles and produces one quotient bit per cycle, MSB first.
  - The bits are: integer bit (always 1), FRAC_W fraction bits, and guard bit g.
  - sticky s = (final partial remainder != 0).
- ROUND (1 cycle):
  - Round up when g & (s | lsb).
  - A mantissa carry-out sets fraction=0 and e=e+1.
  - inexact = g|s.
  - Overflow is checked after rounding. If e >= 2^EXP_W-1, result = signed inf and overflow=inexact=1.
  - Underflow: if e <= 0, result = signed zero and underflow=inexact=1 (flush-to-zero).
- Normal-path latency: out_valid rises exactly Q+2 edges after the accept edge. For binary64 that is 56 edges.
- DONE:
  - out_valid=1 and result/flags are held stable until out_ready=1.
  - On the output handshake the FSM goes to IDLE and out_valid=0 on the next edge.
  - in_ready returns that same edge. The unit never accepts new operands in the same cycle it completes.
- in_valid while busy is ignored; operands are not latched.
- result and flags are not required to be meaningful while out_valid=0; they hold their last values.

Test Plan:
1. Exact binary64 result: a=0x4018000000000000 (6.0), b=0x4000000000000000, out_ready=1 -> result=0x4008000000000000, flags=0, out_valid exactly 56 edges after accept, in_ready=0 throughout.
2. Rounding: a=0x3FF0000000000000, b=0x4008000000000000 (1/3) -> result=0x3FD5555555555555, flags=0x01. Same case with EXP_W=8, FRAC_W=23: a=0x3F800000, b=0x40400000 -> result=0x3EAAAAAB, flags=0x01, latency 27.
3. Specials:
   - 1.0/+0 -> 0x7FF0000000000000, flags=0x08, latency 1.
   - 0/0 -> 0x7FF8000000000000, flags=0x10.
   - -2.0/inf -> 0x8000000000000000, flags=0.
   - subnormal a=0x0000000000000001 / 1.0 -> 0x0, flags=0.
4. Range limits:
   - 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000, flags=0x05.
   - 0x0010000000000000 / 0x4000000000000000 -> 0x0, flags=0x03.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result, flags and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> in_ready=1 on the next edge; a new operand pair is accepted and its result is correct.
6. Reset mid-divide: assert rst_n=0 async at iteration 20 -> out_valid=0, result=0, flags=0 immediately, no stale output. After release, in_ready=1 and 6.0/2.0 completes correctly.
